// File: rtl/shift_issue_ctrl_pkg.sv
// Shared definitions for the shift issue controller: widths, op codes and FSM states.
package shift_issue_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW   = 4;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_issue_ctrl_bit_rev16.sv
// Purely combinational bit reversal; lets a right-only shifter produce left shifts.
module bit_rev16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dout[i] = din[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/shift_issue_ctrl.sv
// Issue/sequencing stage in front of a 16-bit right shifter; builds SRL/SRA/SLL/ROR
// from right shifts plus bit reversal, ROR using two shifter passes.
//
// state | meaning
// IDLE  | waiting for a request
// PASS1 | first shifter pass (all ops)
// PASS2 | second pass, ROR with nonzero amount only
// DONE  | result held until consumer takes it
module shift_issue_ctrl
  import shift_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] sh_a,
  output logic [SHW-1:0]   sh_amt,
  input  logic [WIDTH-1:0] sh_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [SHW-1:0]   sh_amt_q, sh_amt_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [WIDTH-1:0] rev_src;
  logic [WIDTH-1:0] rev_a;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] sra_fill;

  // Operand reversal serves both the SLL load (from in_a) and the ROR second pass (from a_q).
  assign rev_src = (state_q == ST_PASS1) ? a_q : in_a;

  bit_rev16 #(.WIDTH(WIDTH)) u_rev_a (
    .din  (rev_src),
    .dout (rev_a)
  );

  bit_rev16 #(.WIDTH(WIDTH)) u_rev_r (
    .din  (sh_out),
    .dout (rev_out)
  );

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sra_fill = a_q[WIDTH-1] ? ~({WIDTH{1'b1}} >> shamt_q) : '0;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    shamt_d     = shamt_q;
    a_d         = a_q;
    sh_a_d      = sh_a_q;
    sh_amt_d    = sh_amt_q;
    partial_d   = partial_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_PASS1: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        case (op_q)
          OP_SRL: out_data_d = sh_out;
          OP_SRA: out_data_d = sh_out | sra_fill;
          OP_SLL: out_data_d = rev_out;
          default: begin
            if (shamt_q == '0) begin
              out_data_d = sh_out;
            end else begin
              // Left half of the rotate: bitrev(bitrev(a) >> (W-n)) == a << (W-n).
              partial_d   = sh_out;
              sh_a_d      = rev_a;
              sh_amt_d    = SHW'(0) - shamt_q;
              state_d     = ST_PASS2;
              out_valid_d = 1'b0;
            end
          end
        endcase
      end
      ST_PASS2: begin
        out_data_d  = partial_q | rev_out;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      a_d         = in_a;
      op_d        = op_e'(in_op);
      shamt_d     = in_shamt;
      sh_a_d      = (op_e'(in_op) == OP_SLL) ? rev_a : in_a;
      sh_amt_d    = in_shamt;
      out_valid_d = 1'b0;
      state_d     = ST_PASS1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SRL;
      shamt_q     <= '0;
      a_q         <= '0;
      sh_a_q      <= '0;
      sh_amt_q    <= '0;
      partial_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      shamt_q     <= shamt_d;
      a_q         <= a_d;
      sh_a_q      <= sh_a_d;
      sh_amt_q    <= sh_amt_d;
      partial_q   <= partial_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sh_a      = sh_a_q;
  assign sh_amt    = sh_amt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_zero  = (out_data_q == '0);

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl with a behavioural right shifter and an arithmetic reference model.
module tb_shift_issue_ctrl;

  localparam logic [1:0] SRL = 2'b00, SRA = 2'b01, SLL = 2'b10, ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [3:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic [15:0] sh_a;
  logic [3:0]  sh_amt;
  logic [15:0] sh_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_zero;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign sh_out = sh_a >> sh_amt;

  shift_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .sh_out    (sh_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  function automatic logic [15:0] rev(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] n, input logic [1:0] op);
    logic [31:0] dbl;
    case (op)
      SRL: return a >> n;
      SRA: return 16'($signed(a) >>> n);
      SLL: return a << n;
      default: begin
        dbl = {a, a} >> n;
        return dbl[15:0];
      end
    endcase
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives a request and returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [3:0] n, input logic [1:0] op, input logic rel);
    in_valid = 1'b1; in_a = a; in_shamt = n; in_op = op; out_ready = rel;
    #1;
    chk1("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = 16'($urandom); in_shamt = 4'($urandom); in_op = 2'($urandom);
  endtask

  // Follows an accepted op through its passes and checks the result; ends at a negedge in DONE.
  task automatic collect(input string tag, input logic [15:0] a, input logic [3:0] n, input logic [1:0] op);
    int lat;
    int exp_lat;
    logic [15:0] exp_d;
    exp_d   = model(a, n, op);
    exp_lat = (op == ROR && n != 0) ? 2 : 1;
    @(negedge clk);
    chk1({tag, "_pass1_valid"}, out_valid, 1'b0);
    chk16({tag, "_pass1_amt"}, {12'b0, sh_amt}, {12'b0, n});
    chk16({tag, "_pass1_a"}, sh_a, (op == SLL) ? rev(a) : a);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (op == ROR && n != 0 && lat == 1) begin
        chk16({tag, "_pass2_amt"}, {12'b0, sh_amt}, 16'(16 - n));
        chk16({tag, "_pass2_a"}, sh_a, rev(a));
      end
    end while (!out_valid && lat < 6);
    chk16({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    chk16({tag, "_data"}, out_data, exp_d);
    chk1({tag, "_zero"}, out_zero, exp_d == 16'h0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk1("release_valid_low", out_valid, 1'b0);
    chk1("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [3:0]  rn;
    logic [1:0]  rop;

    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data", out_data, 16'h0);
    chk1("rst_out_zero", out_zero, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk16("rst_sh_a", sh_a, 16'h0);
    chk16("rst_sh_amt", {12'b0, sh_amt}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0300, 4'd8, SRL, 1'b0); collect("srl", 16'h0300, 4'd8, SRL); release_out();
    issue(16'h8000, 4'd4, SRA, 1'b0); collect("sra_neg", 16'h8000, 4'd4, SRA); release_out();
    issue(16'h7000, 4'd4, SRA, 1'b0); collect("sra_pos", 16'h7000, 4'd4, SRA); release_out();
    issue(16'h0003, 4'd8, SLL, 1'b0); collect("sll", 16'h0003, 4'd8, SLL); release_out();
    issue(16'h8001, 4'd15, SLL, 1'b0); collect("sll15", 16'h8001, 4'd15, SLL); release_out();
    issue(16'h0001, 4'd1, ROR, 1'b0); collect("ror1", 16'h0001, 4'd1, ROR); release_out();
    issue(16'h1234, 4'd0, ROR, 1'b0); collect("ror0", 16'h1234, 4'd0, ROR); release_out();
    issue(16'h00F0, 4'd4, ROR, 1'b0); collect("ror4", 16'h00F0, 4'd4, ROR); release_out();
    issue(16'h8000, 4'd0, SRA, 1'b0); collect("sra0", 16'h8000, 4'd0, SRA); release_out();
    issue(16'h00FF, 4'd8, SRL, 1'b0); collect("srl_zero", 16'h00FF, 4'd8, SRL); release_out();

    // Backpressure: result held, requests refused, then release+accept in one cycle.
    issue(16'h0300, 4'd8, SRL, 1'b0); collect("bp", 16'h0300, 4'd8, SRL);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'hFFFF; in_shamt = 4'd1; in_op = SLL;
      @(negedge clk);
      chk16("bp_hold_data", out_data, 16'h0003);
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    issue(16'h0003, 4'd8, SLL, 1'b1); collect("bp_next", 16'h0003, 4'd8, SLL); release_out();

    // Reset during ROR PASS2.
    issue(16'h0001, 4'd3, ROR, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_valid", out_valid, 1'b0);
    chk16("midrst_data", out_data, 16'h0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("postrst_no_stale", out_valid, 1'b0);
    end

    // Random ops, mixing overlapped (back-to-back) and separated issue.
    ra = 16'($urandom); rn = 4'($urandom); rop = 2'($urandom);
    issue(ra, rn, rop, 1'b0); collect("rand", ra, rn, rop);
    for (int k = 0; k < 60; k++) begin
      ra  = 16'($urandom);
      rn  = 4'($urandom);
      rop = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        issue(ra, rn, rop, 1'b1);
      end else begin
        release_out();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(ra, rn, rop, 1'b0);
      end
      collect("rand", ra, rn, rop);
    end
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
